// File: rtl/keccak_pkg.sv
// Shared types and per-mode tables for the Keccak squeeze stage: mode encoding,
// rate/digest/last-word byte tables and the squeeze FSM state encoding.
package keccak_pkg;

    typedef enum logic [2:0] {
        CM_SHA3_224 = 3'd0,
        CM_SHA3_256 = 3'd1,
        CM_SHA3_384 = 3'd2,
        CM_SHA3_512 = 3'd3,
        CM_SHAKE128 = 3'd4,
        CM_SHAKE256 = 3'd5
    } cmode_e;

    localparam int N_MODES = 6;

    // Lanes of the state that belong to the rate portion, per mode.
    localparam logic [4:0] RATE_LANES [N_MODES] = '{5'd18, 5'd17, 5'd13, 5'd9, 5'd21, 5'd17};

    // Fixed digest length in 64-bit words; SHAKE length comes from out_len.
    localparam logic [3:0] DIGEST_WORDS [N_MODES] = '{4'd4, 4'd4, 4'd6, 4'd8, 4'd0, 4'd0};

    // Valid bytes in the final word of each mode.
    localparam logic [3:0] LAST_BYTES [N_MODES] = '{4'd4, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};

    typedef enum logic [1:0] {
        SQ_IDLE      = 2'd0,
        SQ_SEND      = 2'd1,
        SQ_WAIT_PERM = 2'd2
    } sq_state_e;

    // Reserved encodings 6/7 behave as SHA3-256.
    function automatic cmode_e norm_mode(input logic [2:0] m);
        if (m > 3'd5) begin
            return CM_SHA3_256;
        end
        return cmode_e'(m);
    endfunction

    function automatic logic is_shake(input cmode_e m);
        return (m == CM_SHAKE128) || (m == CM_SHAKE256);
    endfunction

endpackage

// File: rtl/keccak_lane_mux.sv
// Combinational 25:1 lane select with byte reversal, so lane byte 0 ([7:0])
// lands on output bits [63:56].
module keccak_lane_mux (
    input  logic [1599:0] state_i,
    input  logic [4:0]    lane_idx_i,
    output logic [63:0]   word_o
);

    logic [63:0] lane;

    always_comb begin
        lane = '0;
        for (int k = 0; k < 25; k++) begin
            if (lane_idx_i == 5'(k)) begin
                lane = state_i[64*k +: 64];
            end
        end
        word_o = '0;
        for (int b = 0; b < 8; b++) begin
            word_o[56-8*b +: 8] = lane[8*b +: 8];
        end
    end

endmodule

// File: rtl/buffer_out.sv
// Keccak squeeze stage: captures the permutation state and streams the digest
// as 64-bit words. Optional macro SQUEEZE_ZEROIZE_EN clears the state after use.
module buffer_out
    import keccak_pkg::*;
#(
    parameter int DW    = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cmode,
    input  logic [LEN_W-1:0] out_len,
    input  logic [1599:0]    state_i,
    input  logic             state_valid,
    output logic [DW-1:0]    dt_o,
    output logic             dt_valid,
    input  logic             dt_ready,
    output logic             dt_last,
    output logic [3:0]       dt_bytes,
    output logic             squeeze_req,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state_o
);

    // Handshake: a word transfers on a cycle where dt_valid && dt_ready; while
    // dt_valid is high and dt_ready low, dt_o/dt_last/dt_bytes hold stable.

    sq_state_e        fsm_q, fsm_d;
    logic [1599:0]    state_q, state_d;
    cmode_e           mode_q, mode_d;
    logic [LEN_W-1:0] total_q, total_d;
    logic [LEN_W-1:0] words_sent_q, words_sent_d;
    logic [4:0]       lane_idx_q, lane_idx_d;
    logic             done_q, done_d;
    logic             squeeze_q, squeeze_d;

    logic [63:0]      lane_word;
    logic [63:0]      word_masked;
    logic             fire;
    logic             is_last;
    logic             rate_end;
    cmode_e           cap_mode;

    keccak_lane_mux u_lane_mux (
        .state_i    (state_q),
        .lane_idx_i (lane_idx_q),
        .word_o     (lane_word)
    );

    assign dt_valid    = (fsm_q == SQ_SEND);
    assign fire        = dt_valid && dt_ready;
    assign is_last     = (words_sent_q == (total_q - LEN_W'(1)));
    assign rate_end    = is_shake(mode_q) && (lane_idx_q == (RATE_LANES[mode_q] - 5'd1));
    assign cap_mode    = norm_mode(cmode);

    // A 4-byte final word carries its bytes in the upper half only.
    assign word_masked = (is_last && (LAST_BYTES[mode_q] == 4'd4)) ?
                         {lane_word[63:32], 32'h0} : lane_word;

`ifdef SQUEEZE_ZEROIZE_EN
    assign dt_o = dt_valid ? word_masked : '0;
`else
    assign dt_o = word_masked;
`endif

    assign dt_last     = dt_valid && is_last;
    assign dt_bytes    = dt_valid ? (is_last ? LAST_BYTES[mode_q] : 4'd8) : 4'd0;
    assign squeeze_req = squeeze_q;
    assign done        = done_q;
    assign busy        = (fsm_q != SQ_IDLE);
    assign fsm_state_o = fsm_q;

    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        mode_d       = mode_q;
        total_d      = total_q;
        words_sent_d = words_sent_q;
        lane_idx_d   = lane_idx_q;
        done_d       = 1'b0;
        squeeze_d    = 1'b0;

`ifdef SQUEEZE_ZEROIZE_EN
        if (done_q) begin
            state_d = '0;
        end
`endif

        case (fsm_q)
            SQ_IDLE: begin
                if (state_valid) begin
                    state_d      = state_i;
                    mode_d       = cap_mode;
                    total_d      = is_shake(cap_mode) ? out_len : LEN_W'(DIGEST_WORDS[cap_mode]);
                    words_sent_d = '0;
                    lane_idx_d   = '0;
                    if (is_shake(cap_mode) && (out_len == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        fsm_d = SQ_SEND;
                    end
                end
            end
            SQ_SEND: begin
                if (fire) begin
                    words_sent_d = words_sent_q + LEN_W'(1);
                    lane_idx_d   = lane_idx_q + 5'd1;
                    if (is_last) begin
                        done_d = 1'b1;
                        fsm_d  = SQ_IDLE;
                    end else if (rate_end) begin
                        lane_idx_d = '0;
                        squeeze_d  = 1'b1;
                        fsm_d      = SQ_WAIT_PERM;
                    end
                end
            end
            SQ_WAIT_PERM: begin
                if (state_valid) begin
                    state_d = state_i;
                    fsm_d   = SQ_SEND;
                end
            end
            default: begin
                fsm_d = SQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= SQ_IDLE;
            state_q      <= '0;
            mode_q       <= CM_SHA3_224;
            total_q      <= '0;
            words_sent_q <= '0;
            lane_idx_q   <= '0;
            done_q       <= 1'b0;
            squeeze_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            mode_q       <= mode_d;
            total_q      <= total_d;
            words_sent_q <= words_sent_d;
            lane_idx_q   <= lane_idx_d;
            done_q       <= done_d;
            squeeze_q    <= squeeze_d;
        end
    end

endmodule

// File: tb/tb_buffer_out.sv
// Randomized scoreboard bench for buffer_out: a word-level reference model fills
// an expected queue, an independent monitor pops and compares each accepted word.
module tb_buffer_out;

    logic           clk;
    logic           rst;
    logic [2:0]     cmode;
    logic [15:0]    out_len;
    logic [1599:0]  state_i;
    logic           state_valid;
    logic [63:0]    dt_o;
    logic           dt_valid;
    logic           dt_ready;
    logic           dt_last;
    logic [3:0]     dt_bytes;
    logic           squeeze_req;
    logic           busy;
    logic           done;
    logic [1:0]     fsm_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int words_rx = 0;
    int sq_cnt   = 0;
    int done_cnt = 0;
    int last_hs_cyc = -10;
    int ready_mode  = 0;
    logic busy_seen = 1'b0;

    // Expected entry: {data[63:0], last, bytes[3:0]}
    logic [68:0] exp_q[$];

    buffer_out dut (
        .clk         (clk),
        .rst         (rst),
        .cmode       (cmode),
        .out_len     (out_len),
        .state_i     (state_i),
        .state_valid (state_valid),
        .dt_o        (dt_o),
        .dt_valid    (dt_valid),
        .dt_ready    (dt_ready),
        .dt_last     (dt_last),
        .dt_bytes    (dt_bytes),
        .squeeze_req (squeeze_req),
        .busy        (busy),
        .done        (done),
        .fsm_state_o (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] bswap(input logic [63:0] x);
        logic [63:0] y;
        for (int b = 0; b < 8; b++) y[8*(7-b) +: 8] = x[8*b +: 8];
        return y;
    endfunction

    function automatic logic [1599:0] rnd_state();
        logic [1599:0] s;
        for (int k = 0; k < 50; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    // ---------------- ready driver ----------------
    initial begin
        dt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dt_ready = 1'b1;
                1:       dt_ready = ~dt_ready;
                default: dt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        stall_pend = 1'b0;
    logic [68:0] stall_val;
    initial begin
        logic [68:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    check("stall_valid_held", dt_valid, 1'b1);
                    check("stall_stable", {dt_o, dt_last, dt_bytes}, stall_val);
                end
                if (dt_valid && dt_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", dt_o, e[68:5]);
                        check("word_last", dt_last, e[4]);
                        check("word_bytes", dt_bytes, e[3:0]);
                    end
                    words_rx++;
                    if (dt_last) last_hs_cyc = cyc;
                end
                stall_pend = dt_valid && !dt_ready;
                stall_val  = {dt_o, dt_last, dt_bytes};
                if (squeeze_req) sq_cnt++;
                if (done) done_cnt++;
                if (busy) busy_seen = 1'b1;
            end
        end
    end

    // ---------------- reference model + driver ----------------
    task automatic pulse_state(input logic [1599:0] s);
        @(posedge clk);
        #1;
        state_i     = s;
        state_valid = 1'b1;
        @(posedge clk);
        #1;
        state_valid = 1'b0;
        state_i     = rnd_state();
    endtask

    task automatic run(input logic [2:0] cm, input int len, input int rdy, input int gap,
                       input bit fix0);
        int mode, total, rate, nblk, bi, sq0, dn0, wr0, budget;
        bit got_done;
        logic [1599:0] blk[$];
        logic [63:0] d;
        logic [1599:0] s;

        mode = (cm > 3'd5) ? 1 : int'(cm);
        case (mode)
            0: begin total = 4;   rate = 18; end
            1: begin total = 4;   rate = 17; end
            2: begin total = 6;   rate = 13; end
            3: begin total = 8;   rate = 9;  end
            4: begin total = len; rate = 21; end
            default: begin total = len; rate = 17; end
        endcase
        nblk = (total == 0) ? 1 : (total + rate - 1) / rate;
        for (int b = 0; b < nblk; b++) begin
            s = rnd_state();
            if (fix0 && b == 0) s[63:0] = 64'h0706050403020100;
            blk.push_back(s);
        end
        for (int i = 0; i < total; i++) begin
            s = blk[i / rate];
            d = bswap(s[64*(i % rate) +: 64]);
            if (mode == 0 && i == total - 1) d[31:0] = 32'h0;
            exp_q.push_back({d, (i == total - 1), ((mode == 0 && i == total - 1) ? 4'd4 : 4'd8)});
        end

        ready_mode = rdy;
        sq0 = sq_cnt;
        dn0 = done_cnt;
        wr0 = words_rx;
        busy_seen = 1'b0;
        cmode   = cm;
        out_len = 16'(len);
        pulse_state(blk[0]);
        cmode   = 3'($urandom);
        out_len = 16'($urandom);

        if (total == 0) begin
            check("zero_len_done", done, 1'b1);
            check("zero_len_busy", busy, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            check("zero_len_done_count", 32'(done_cnt - dn0), 32'd1);
            check("zero_len_busy_never", busy_seen, 1'b0);
            check("zero_len_no_words", 32'(words_rx - wr0), 32'd0);
            return;
        end

        check("first_valid_latency", dt_valid, 1'b1);
        check("busy_after_capture", busy, 1'b1);

        bi = 0;
        got_done = 0;
        budget = 4000;
        while (budget > 0 && !got_done) begin
            @(negedge clk);
            budget--;
            if (done) begin
                got_done = 1;
                check("done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
            end else if (squeeze_req) begin
                bi++;
                if (bi >= nblk) begin
                    check("extra_squeeze", 1'b1, 1'b0);
                end else begin
                    repeat (gap) @(posedge clk);
                    pulse_state(blk[bi]);
                end
            end
        end
        if (!got_done) check("done_timeout", 1'b0, 1'b1);

        @(negedge clk);
        #1;
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        check("words_drained", 32'(exp_q.size()), 32'd0);
        check("word_count", 32'(words_rx - wr0), 32'(total));
        check("squeeze_count", 32'(sq_cnt - sq0), 32'(nblk - 1));
        check("done_count", 32'(done_cnt - dn0), 32'd1);
        exp_q.delete();
    endtask

    task automatic reset_midstream();
        int dn0, wr0, budget;
        logic [1599:0] s;
        s = rnd_state();
        for (int i = 0; i < 6; i++)
            exp_q.push_back({bswap(s[64*i +: 64]), (i == 5), 4'd8});
        ready_mode = 0;
        dn0 = done_cnt;
        wr0 = words_rx;
        cmode   = 3'd2;
        out_len = 16'd0;
        pulse_state(s);
        budget = 100;
        while (budget > 0 && (words_rx - wr0) < 3) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) check("reset_word3_timeout", 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_dt_valid", dt_valid, 1'b0);
        check("rst_dt_o", dt_o, 64'h0);
        check("rst_dt_last", dt_last, 1'b0);
        check("rst_dt_bytes", dt_bytes, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_squeeze", squeeze_req, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt - dn0), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst         = 1'b1;
        cmode       = 3'd0;
        out_len     = 16'd0;
        state_i     = '0;
        state_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dt_valid", dt_valid, 1'b0);
        check("reset_dt_o", dt_o, 64'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_squeeze", squeeze_req, 1'b0);
        check("reset_fsm_idle", fsm_state, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(3'd1, 0, 0, 0, 1'b1);      // SHA3-256, fixed lane0
        run(3'd0, 0, 0, 0, 1'b0);      // SHA3-224 short last word
        run(3'd3, 0, 1, 0, 1'b0);      // SHA3-512 with toggling ready
        run(3'd4, 30, 0, 24, 1'b0);    // SHAKE128 across one squeeze
        run(3'd5, 0, 0, 0, 1'b0);      // SHAKE256 zero length
        run(3'd5, 17, 0, 0, 1'b0);     // SHAKE256 exactly one rate block
        run(3'd6, 0, 2, 0, 1'b0);      // reserved mode acts as SHA3-256
        run(3'd5, 40, 2, 3, 1'b0);     // SHAKE256 with two squeezes
        reset_midstream();
        run(3'd1, 0, 0, 0, 1'b0);      // clean restart after abort
        for (int r = 0; r < 6; r++) begin
            run(3'($urandom_range(0, 7)), $urandom_range(1, 60), 2,
                $urandom_range(0, 10), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
